// File: rtl/sram_pkt_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sram_pkt_pkg
// Description : Shared types for the packet ingress framer.
//               - drop reason codes
//               - ingress FSM states
//               - buffered beat layout
// Revision    : 1.0  initial release
// ============================================================================
package sram_pkt_pkg;

  // Byte width of a buffered beat. It must match the framer DATA_W.
  localparam int PKT_DATA_W = 8;

  typedef enum logic [1:0] {
    DROP_TOO_SHORT  = 2'd0,
    DROP_ORPHAN     = 2'd1,
    DROP_SOP_IN_PKT = 2'd2,
    DROP_TOO_LONG   = 2'd3
  } drop_code_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RECV    = 2'd1,
    ST_DISCARD = 2'd2
  } ingress_state_e;

  typedef struct packed {
    logic                  sop;
    logic                  eop;
    logic [PKT_DATA_W-1:0] data;
  } pkt_beat_t;

endpackage
`default_nettype wire

// File: rtl/pkt_byte_buf.sv
`default_nettype none
// ============================================================================
// Module      : pkt_byte_buf
// Description : Flop array of DEPTH packet beats.
//               - one synchronous write port
//               - one asynchronous read port
//               All pointer management lives in the framer.
// Revision    : 1.0  initial release
// ============================================================================
module pkt_byte_buf
  import sram_pkt_pkg::*;
#(
  parameter int DEPTH = 256,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  pkt_beat_t     wr_beat,
  input  logic [AW-1:0] rd_addr,
  output pkt_beat_t     rd_beat
);

  pkt_beat_t mem [DEPTH];

  // Storage write. There is no reset: validity is tracked by the pointers.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_beat;
    end
  end

  assign rd_beat = mem[rd_addr];

endmodule
`default_nettype wire

// File: rtl/pkt_ingress_framer.sv
`default_nettype none
// ============================================================================
// Module      : pkt_ingress_framer
// Description : Store-and-forward framer in front of one SRAM write port.
//               - Buffers each packet until its eop arrives.
//               - Forwards only well-formed packets.
//               - Reports every discard with a one-cycle drop pulse.
//               Optional macro PKT_INGRESS_STATS_EN adds the
//               pkt_ok_cnt / pkt_drop_cnt counters.
// Revision    : 1.0  initial release
// ============================================================================
module pkt_ingress_framer
  import sram_pkt_pkg::*;
#(
  parameter int DATA_W  = PKT_DATA_W,
  parameter int DEPTH   = 256,
  parameter int MIN_LEN = 2,
  parameter int MAX_LEN = 128
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_sop,
  input  logic              in_eop,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_sop,
  output logic              out_eop,
  input  logic              out_ready,
  output logic              drop_valid,
  output logic [1:0]        drop_code
`ifdef PKT_INGRESS_STATS_EN
  ,
  output logic [31:0]       pkt_ok_cnt,
  output logic [31:0]       pkt_drop_cnt
`endif
);

  localparam int AW    = $clog2(DEPTH);
  localparam int PTR_W = AW + 1;
  localparam int LEN_W = $clog2(MAX_LEN + 2);

  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [PTR_W-1:0] PTR_DEPTH = PTR_W'(DEPTH);
  localparam logic [LEN_W-1:0] LEN_ONE   = LEN_W'(1);
  localparam logic [LEN_W-1:0] LEN_MIN   = LEN_W'(MIN_LEN);
  localparam logic [LEN_W-1:0] LEN_MAX   = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] LEN_SAT   = LEN_W'(MAX_LEN + 1);

  ingress_state_e   state, state_nxt;
  logic [LEN_W-1:0] len, len_nxt;
  logic [PTR_W-1:0] wr_ptr, wr_ptr_nxt;
  logic [PTR_W-1:0] commit_ptr, commit_ptr_nxt;
  logic [PTR_W-1:0] rd_ptr;
  logic             drop_valid_r, drop_valid_nxt;
  drop_code_e       drop_code_r, drop_code_nxt;

  logic             accept;
  logic             full;
  logic [PTR_W-1:0] used;
  logic [LEN_W-1:0] len_inc;

  logic             buf_wr_en;
  logic [AW-1:0]    buf_wr_addr;
  pkt_beat_t        buf_wr_beat;
  pkt_beat_t        buf_rd_beat;

  // Occupancy counts every written byte, committed or not, against the
  // registered read pointer, so a read frees space one cycle later.
  assign used     = wr_ptr - rd_ptr;
  assign full     = (used == PTR_DEPTH);
  assign in_ready = (state == ST_DISCARD) || !full;
  assign accept   = in_valid && in_ready;
  assign len_inc  = len + LEN_ONE;

  assign buf_wr_beat.sop  = in_sop;
  assign buf_wr_beat.eop  = in_eop;
  assign buf_wr_beat.data = in_data;

  // Egress only ever sees committed bytes.
  assign out_valid = (rd_ptr != commit_ptr);
  assign out_data  = buf_rd_beat.data;
  assign out_sop   = buf_rd_beat.sop;
  assign out_eop   = buf_rd_beat.eop;

  assign drop_valid = drop_valid_r;
  assign drop_code  = drop_code_r;

  pkt_byte_buf #(
    .DEPTH (DEPTH)
  ) u_buf (
    .clock   (clock),
    .wr_en   (buf_wr_en),
    .wr_addr (buf_wr_addr),
    .wr_beat (buf_wr_beat),
    .rd_addr (rd_ptr[AW-1:0]),
    .rd_beat (buf_rd_beat)
  );

  // Ingress next-state: framing checks, buffer writes, commit and rewind.
  always_comb begin
    state_nxt      = state;
    len_nxt        = len;
    wr_ptr_nxt     = wr_ptr;
    commit_ptr_nxt = commit_ptr;
    drop_valid_nxt = 1'b0;
    drop_code_nxt  = drop_code_r;
    buf_wr_en      = 1'b0;
    buf_wr_addr    = wr_ptr[AW-1:0];

    if (accept) begin
      unique case (state)
        ST_IDLE: begin
          if (!in_sop) begin
            drop_valid_nxt = 1'b1;
            drop_code_nxt  = DROP_ORPHAN;
          end else begin
            buf_wr_en  = 1'b1;
            len_nxt    = LEN_ONE;
            wr_ptr_nxt = wr_ptr + PTR_ONE;
            if (in_eop) begin
              if (LEN_ONE >= LEN_MIN) begin
                commit_ptr_nxt = wr_ptr + PTR_ONE;
              end else begin
                wr_ptr_nxt     = commit_ptr;
                drop_valid_nxt = 1'b1;
                drop_code_nxt  = DROP_TOO_SHORT;
              end
            end else begin
              state_nxt = ST_RECV;
            end
          end
        end

        ST_RECV: begin
          if (in_sop) begin
            // Abandon the open packet and restart at the last commit point.
            // When this sop beat is also a too-short eop, the single drop
            // pulse reports the abandoned packet.
            drop_valid_nxt = 1'b1;
            drop_code_nxt  = DROP_SOP_IN_PKT;
            buf_wr_en      = 1'b1;
            buf_wr_addr    = commit_ptr[AW-1:0];
            wr_ptr_nxt     = commit_ptr + PTR_ONE;
            len_nxt        = LEN_ONE;
            if (in_eop) begin
              state_nxt = ST_IDLE;
              if (LEN_ONE >= LEN_MIN) begin
                commit_ptr_nxt = commit_ptr + PTR_ONE;
              end else begin
                wr_ptr_nxt = commit_ptr;
              end
            end
          end else if (len >= LEN_MAX) begin
            wr_ptr_nxt     = commit_ptr;
            len_nxt        = LEN_SAT;
            drop_valid_nxt = 1'b1;
            drop_code_nxt  = DROP_TOO_LONG;
            state_nxt      = in_eop ? ST_IDLE : ST_DISCARD;
          end else begin
            buf_wr_en  = 1'b1;
            wr_ptr_nxt = wr_ptr + PTR_ONE;
            len_nxt    = len_inc;
            if (in_eop) begin
              state_nxt = ST_IDLE;
              if (len_inc >= LEN_MIN) begin
                commit_ptr_nxt = wr_ptr + PTR_ONE;
              end else begin
                wr_ptr_nxt     = commit_ptr;
                drop_valid_nxt = 1'b1;
                drop_code_nxt  = DROP_TOO_SHORT;
              end
            end
          end
        end

        ST_DISCARD: begin
          if (in_eop) begin
            state_nxt = ST_IDLE;
          end
        end

        default: begin
          state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  // State, pointer and drop-report registers.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      len          <= '0;
      wr_ptr       <= '0;
      commit_ptr   <= '0;
      rd_ptr       <= '0;
      drop_valid_r <= 1'b0;
      drop_code_r  <= DROP_TOO_SHORT;
    end else begin
      state        <= state_nxt;
      len          <= len_nxt;
      wr_ptr       <= wr_ptr_nxt;
      commit_ptr   <= commit_ptr_nxt;
      drop_valid_r <= drop_valid_nxt;
      drop_code_r  <= drop_code_nxt;
      if (out_valid && out_ready) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end

`ifdef PKT_INGRESS_STATS_EN
  logic [31:0] ok_cnt;
  logic [31:0] drp_cnt;

  // Packet statistics. A commit always moves commit_ptr, so any change
  // of it marks one good packet.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      ok_cnt  <= '0;
      drp_cnt <= '0;
    end else begin
      if (commit_ptr_nxt != commit_ptr) begin
        ok_cnt <= ok_cnt + 32'd1;
      end
      if (drop_valid_r) begin
        drp_cnt <= drp_cnt + 32'd1;
      end
    end
  end

  assign pkt_ok_cnt   = ok_cnt;
  assign pkt_drop_cnt = drp_cnt;
`endif

endmodule
`default_nettype wire
